simd_operand_loader: RTL and testbench
======================================

SIMD_OPERAND_LOADER -- requirements
Module: simd_operand_loader

Interface
REQ-001 Parameter: SIMD_WIDTH, default 256, operand width in bits.
REQ-002 Parameter: BEAT_WIDTH, default 64, input bus width in bits; SIMD_WIDTH/BEAT_WIDTH beats per operand (default 4).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous abort of the current transaction.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command can be accepted.
REQ-008 cmd_mode  input  3  element mode: 0=8b, 1=16b, 2=32b, 3=64b, 4=128b, 5..7=256b pass-through.
REQ-009 cmd_hi  input  1  select high halves, not low halves.
REQ-010 in_valid  input  1  operand beat present.
REQ-011 in_ready  output  1  operand beat can be accepted.
REQ-012 in_data  input  BEAT_WIDTH  operand beat.
REQ-013 out_valid  output  1  A, B, data_mode and hi_flag are complete and stable.
REQ-014 out_ready  input  1  downstream unpack stage consumes the operand set.
REQ-015 A, B  output  SIMD_WIDTH each  assembled operands.
REQ-016 data_mode  output  3, and hi_flag  output  1: latched command fields, wired directly to the unpack stage.
REQ-017 err  output  1  one-cycle illegal-mode pulse; present only when the Configuration macro is defined.

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD_A, LOAD_B and HOLD.
REQ-019 In IDLE, cmd_ready SHALL be 1; a cmd_valid handshake SHALL latch cmd_mode and cmd_hi into data_mode and hi_flag, and the FSM SHALL go to LOAD_A with the beat counter at 0.
REQ-020 In LOAD_A and LOAD_B, in_ready SHALL be 1; each in_valid beat k (k = 0 first) SHALL be written to operand bits [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH], little-endian, and the counter SHALL increment.
REQ-021 A cycle with in_valid low SHALL not advance the counter or change operand data.
REQ-022 After the last beat of A, the FSM SHALL go to LOAD_B with the counter at 0; after the last beat of B, it SHALL go to HOLD.
REQ-023 In HOLD, out_valid SHALL be 1, and A, B, data_mode and hi_flag SHALL not change while out_ready is low.
REQ-024 A HOLD cycle with out_ready high SHALL return the FSM to IDLE.
REQ-025 Minimum transaction time SHALL be 10 cycles: 1 command, 8 beats, 1 output handshake.
REQ-026 cmd_ready, in_ready and out_valid SHALL be mutually exclusive and decoded from state only, with no combinational path from any input.
REQ-027 flush SHALL force IDLE, clear the counter and out_valid next cycle, and leave A and B contents unchanged.
REQ-028 flush SHALL override any handshake in the same cycle; that beat, command or output SHALL be treated as not accepted.
REQ-029 Command or beat signals presented in states that do not accept them SHALL be ignored.

Reset
REQ-030 While rst is high, next state SHALL be IDLE, the counter 0, A and B all-zero, data_mode 0 and hi_flag 0.
REQ-031 After rst, outputs SHALL be cmd_ready=1, in_ready=0, out_valid=0 and err=0.
REQ-032 rst SHALL take priority over flush and over all handshakes, including in the middle of a transaction.

Configuration
REQ-033 Macro SIMD_LOADER_MODE_CHECK_EN SHALL control the illegal-mode check.
REQ-034 With SIMD_LOADER_MODE_CHECK_EN defined, a command with cmd_mode 6 or 7 SHALL be accepted (cmd_ready handshake), pulse err for one cycle, leave the FSM in IDLE, and leave data_mode and hi_flag unchanged.
REQ-035 Without the macro, the err port SHALL not exist, and modes 5..7 SHALL load normally as 256-bit pass-through.

Structure
REQ-036 Shared package simd_pkg SHALL hold SIMD_WIDTH, BEAT_WIDTH, BEATS, the data_mode encodings and the loader state enum.
REQ-037 Sub-module simd_operand_reg SHALL be a beat-indexed SIMD_WIDTH register with write-enable and beat index, instantiated twice (A and B); FSM and counter stay in the top.

Verification
REQ-038 Command mode=0, hi=0, then beats A=1,2,3,4 and B=5,6,7,8 with out_ready=1 -> A=0x0000000000000004_..03_..02_..01, B holds 8..5 in the same order, out_valid high for exactly 1 cycle, cycle 10 after the command.
REQ-039 Same load with out_ready=0 for 5 cycles -> out_valid held 5+ cycles, A, B, data_mode and hi_flag unchanged, in_ready=0, cmd_ready=0.
REQ-040 in_valid toggled 1,0,1,0 during LOAD_A -> exactly 2 beats captured; the counter does not advance on idle cycles.
REQ-041 flush asserted together with the 2nd beat of B -> next cycle IDLE, that beat not written, out_valid=0; a fresh 10-cycle transaction then completes correctly.
REQ-042 rst asserted in LOAD_B -> next cycle A=B=0, cmd_ready=1, data_mode=0.
REQ-043 With SIMD_LOADER_MODE_CHECK_EN defined, command mode=7 -> err=1 for one cycle, FSM stays IDLE, in_ready=0; then mode=5 loads normally.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD operand loader: operand/beat geometry,
// element-mode encodings and the loader state enum.
package simd_pkg;

    localparam int SIMD_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = SIMD_WIDTH / BEAT_WIDTH;

    localparam logic [2:0] MODE_8B    = 3'd0;
    localparam logic [2:0] MODE_16B   = 3'd1;
    localparam logic [2:0] MODE_32B   = 3'd2;
    localparam logic [2:0] MODE_64B   = 3'd3;
    localparam logic [2:0] MODE_128B  = 3'd4;
    localparam logic [2:0] MODE_256B  = 3'd5;
    localparam logic [2:0] MODE_RSVD6 = 3'd6;
    localparam logic [2:0] MODE_RSVD7 = 3'd7;

    typedef enum logic [1:0] {
        LS_IDLE   = 2'd0,
        LS_LOAD_A = 2'd1,
        LS_LOAD_B = 2'd2,
        LS_HOLD   = 2'd3
    } loader_state_e;

    // Modes 6 and 7 have no defined element size; the optional check rejects them.
    function automatic logic mode_is_illegal(input logic [2:0] mode);
        return (mode == MODE_RSVD6) || (mode == MODE_RSVD7);
    endfunction

endpackage

// File: rtl/simd_operand_reg.sv
// Beat-indexed operand register: one BEAT_WIDTH slice written per enabled
// cycle, slice selected by beat_idx (little-endian, beat 0 at the LSBs).
module simd_operand_reg #(
    parameter int SIMD_WIDTH = simd_pkg::SIMD_WIDTH,
    parameter int BEAT_WIDTH = simd_pkg::BEAT_WIDTH,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    output logic [SIMD_WIDTH-1:0] data
);

    localparam int NUM_BEATS = SIMD_WIDTH / BEAT_WIDTH;

    // Write the addressed slice; all other slices keep their contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            for (int k = 0; k < NUM_BEATS; k++) begin
                if (wr_en && (beat_idx == IDX_W'(k))) begin
                    data[k*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
                end
            end
        end
    end

endmodule

// File: rtl/simd_operand_loader.sv
// SIMD operand loader: accepts a command, assembles operand A then operand B
// from BEAT_WIDTH beats, and holds the pair until the unpack stage takes it.
// Optional macro SIMD_LOADER_MODE_CHECK_EN adds the err port and rejects
// commands with reserved modes 6/7.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a command (cmd_ready)
// LOAD_A  | collecting beats of operand A (in_ready)
// LOAD_B  | collecting beats of operand B (in_ready)
// HOLD    | operand set presented (out_valid) until out_ready
module simd_operand_loader #(
    parameter int SIMD_WIDTH = simd_pkg::SIMD_WIDTH,
    parameter int BEAT_WIDTH = simd_pkg::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_mode,
    input  logic                  cmd_hi,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BEAT_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] A,
    output logic [SIMD_WIDTH-1:0] B,
    output logic [2:0]            data_mode,
    output logic                  hi_flag
`ifdef SIMD_LOADER_MODE_CHECK_EN
    ,
    output logic                  err
`endif
);

    import simd_pkg::*;

    localparam int NUM_BEATS = SIMD_WIDTH / BEAT_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    localparam logic [1:0] ST_IDLE   = LS_IDLE;
    localparam logic [1:0] ST_LOAD_A = LS_LOAD_A;
    localparam logic [1:0] ST_LOAD_B = LS_LOAD_B;
    localparam logic [1:0] ST_HOLD   = LS_HOLD;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode_reject;
    logic             cmd_fire;
    logic             beat_fire;
    logic             last_beat;
    logic             wr_a, wr_b;

`ifdef SIMD_LOADER_MODE_CHECK_EN
    assign mode_reject = mode_is_illegal(cmd_mode);
`else
    assign mode_reject = 1'b0;
`endif

    // Handshake flags are pure state decodes so no input reaches them.
    assign cmd_ready = (state == ST_IDLE);
    assign in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign out_valid = (state == ST_HOLD);

    // flush cancels whatever handshake coincides with it.
    assign cmd_fire  = cmd_valid && cmd_ready && !flush;
    assign beat_fire = in_valid && in_ready && !flush;
    assign last_beat = (cnt == LAST_CNT);
    assign wr_a      = beat_fire && (state == ST_LOAD_A);
    assign wr_b      = beat_fire && (state == ST_LOAD_B);

    // Next-state and beat-counter decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && !mode_reject) begin
                        state_nxt = ST_LOAD_A;
                        cnt_nxt   = '0;
                    end
                end
                ST_LOAD_A: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            state_nxt = ST_LOAD_B;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            state_nxt = ST_HOLD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch command fields on an accepted, legal command only.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_mode <= 3'd0;
            hi_flag   <= 1'b0;
        end else if (cmd_fire && !mode_reject) begin
            data_mode <= cmd_mode;
            hi_flag   <= cmd_hi;
        end
    end

`ifdef SIMD_LOADER_MODE_CHECK_EN
    // One-cycle pulse for an accepted command carrying a reserved mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= cmd_fire && mode_reject;
        end
    end
`endif

    simd_operand_reg #(
        .SIMD_WIDTH (SIMD_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .IDX_W      (CNT_W)
    ) u_reg_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_a),
        .beat_idx  (cnt),
        .beat_data (in_data),
        .data      (A)
    );

    simd_operand_reg #(
        .SIMD_WIDTH (SIMD_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .IDX_W      (CNT_W)
    ) u_reg_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_b),
        .beat_idx  (cnt),
        .beat_data (in_data),
        .data      (B)
    );

endmodule

// File: tb/tb_simd_operand_loader.sv
// Bench for simd_operand_loader: randomized transactions checked by a
// queue-based scoreboard, plus directed stall, gap, flush and reset cases.
// Define SIMD_LOADER_MODE_CHECK_EN to exercise the reserved-mode check.
module tb_simd_operand_loader;

    import simd_pkg::*;

    localparam int SW = 256;
    localparam int BW = 64;
    localparam int NB = SW / BW;

    typedef struct {
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic [2:0]    mode;
        logic          hi;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_mode = 3'd0;
    logic          cmd_hi = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] A, B;
    logic [2:0]    data_mode;
    logic          hi_flag;
`ifdef SIMD_LOADER_MODE_CHECK_EN
    logic          err;
`endif

    int errors = 0;
    int checks = 0;

    exp_t          exp_q[$];
    logic [SW-1:0] mdl_a = '0;
    logic [SW-1:0] mdl_b = '0;
    logic [2:0]    mdl_mode = 3'd0;
    logic          mdl_hi = 1'b0;
    logic [BW-1:0] beats_a[NB];
    logic [BW-1:0] beats_b[NB];

    simd_operand_loader #(.SIMD_WIDTH(SW), .BEAT_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_hi    (cmd_hi),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .data_mode (data_mode),
        .hi_flag   (hi_flag)
`ifdef SIMD_LOADER_MODE_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] pack_beats(input logic [BW-1:0] bt[NB]);
        logic [SW-1:0] v;
        for (int k = 0; k < NB; k++) v[k*BW +: BW] = bt[k];
        return v;
    endfunction

    task automatic randomize_beats();
        for (int k = 0; k < NB; k++) begin
            beats_a[k] = {$urandom, $urandom};
            beats_b[k] = {$urandom, $urandom};
        end
    endtask

    // Presents a command and waits (bounded) for it to be taken.
    task automatic send_cmd(input logic [2:0] mode, input logic hi);
        int n = 0;
        cmd_mode  = mode;
        cmd_hi    = hi;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_wait_timeout", 1'(n >= 50), 1'b0);
        tick();
        cmd_valid = 1'b0;
        cmd_mode  = 3'($urandom);
    endtask

    task automatic send_beat(input logic [BW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("beat_wait_timeout", 1'(n >= 50), 1'b0);
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
    endtask

    // gap_mode: 0 back-to-back, 1 random idle cycles (with stray commands),
    // 2 one idle cycle after each A beat. lat = cycles from command
    // presentation until out_valid is seen.
    task automatic run_txn(input logic [2:0] mode, input logic hi, input int gap_mode,
                           input int stall, output int lat);
        exp_t e;
        int   n;
        e.a    = pack_beats(beats_a);
        e.b    = pack_beats(beats_b);
        e.mode = mode;
        e.hi   = hi;
        exp_q.push_back(e);
        lat = 0;
        send_cmd(mode, hi);
        lat++;
        for (int k = 0; k < 2*NB; k++) begin
            if (gap_mode == 1) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    in_data   = {$urandom, $urandom};
                    cmd_valid = 1'b1;
                    cmd_mode  = 3'($urandom);
                    tick();
                    lat++;
                end
                cmd_valid = 1'b0;
            end
            send_beat((k < NB) ? beats_a[k] : beats_b[k-NB]);
            lat++;
            if (gap_mode == 2 && k < NB) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                tick();
                lat++;
            end
        end
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            lat++;
            n++;
        end
        chk("out_valid_timeout", 1'(n >= 20), 1'b0);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = {$urandom, $urandom};
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mdl_a    = e.a;
        mdl_b    = e.b;
        mdl_mode = e.mode;
        mdl_hi   = e.hi;
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks
    // hold-stability and handshake exclusivity every cycle.
    logic          prev_hold = 1'b0;
    logic [SW-1:0] prev_a, prev_b;
    logic [2:0]    prev_mode;
    logic          prev_hi;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("handshake_onehot", SW'(int'(cmd_ready) + int'(in_ready) + int'(out_valid)), SW'(1));
            if (prev_hold && out_valid) begin
                chk("hold_A_stable", A, prev_a);
                chk("hold_B_stable", B, prev_b);
                chk("hold_mode_stable", data_mode, prev_mode);
                chk("hold_hi_stable", hi_flag, prev_hi);
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_A", A, e.a);
                    chk("sb_B", B, e.b);
                    chk("sb_data_mode", data_mode, e.mode);
                    chk("sb_hi_flag", hi_flag, e.hi);
                end
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_a    = A;
            prev_b    = B;
            prev_mode = data_mode;
            prev_hi   = hi_flag;
        end
    end

    initial begin
        int            lat;
        logic [SW-1:0] exp_b;
        logic [2:0]    m;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_A", A, '0);
        chk("rst_B", B, '0);
        chk("rst_data_mode", data_mode, 3'd0);
        chk("rst_hi_flag", hi_flag, 1'b0);
`ifdef SIMD_LOADER_MODE_CHECK_EN
        chk("rst_err", err, 1'b0);
`endif

        // Basic load with back-to-back beats and immediate consume.
        for (int k = 0; k < NB; k++) begin
            beats_a[k] = BW'(k + 1);
            beats_b[k] = BW'(k + 5);
        end
        run_txn(3'd0, 1'b0, 0, 0, lat);
        chk("basic_latency", SW'(lat), SW'(9));
        chk("basic_out_valid_one_cycle", out_valid, 1'b0);
        chk("basic_cmd_ready_after", cmd_ready, 1'b1);
        chk("basic_A_literal", A,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
        chk("basic_B_literal", B,
            256'h0000000000000008_0000000000000007_0000000000000006_0000000000000005);

        // Downstream stall for 5 cycles.
        randomize_beats();
        run_txn(3'd3, 1'b1, 0, 5, lat);

        // in_valid alternating 1,0,1,0 during LOAD_A.
        randomize_beats();
        run_txn(3'd1, 1'b0, 2, 0, lat);
        chk("gap_latency", SW'(lat), SW'(13));

        // flush coinciding with the second beat of B.
        randomize_beats();
        send_cmd(3'd2, 1'b1);
        for (int k = 0; k < NB; k++) send_beat(beats_a[k]);
        send_beat(beats_b[0]);
        in_valid = 1'b1;
        in_data  = beats_b[1];
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_b = mdl_b;
        exp_b[0 +: BW] = beats_b[0];
        chk("flush_cmd_ready", cmd_ready, 1'b1);
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_A_kept", A, pack_beats(beats_a));
        chk("flush_B_beat_not_written", B, exp_b);
        mdl_a = pack_beats(beats_a);
        mdl_b = exp_b;
        randomize_beats();
        run_txn(3'd4, 1'b0, 0, 0, lat);
        chk("post_flush_latency", SW'(lat), SW'(9));

        // rst in the middle of LOAD_B.
        randomize_beats();
        send_cmd(3'd1, 1'b1);
        for (int k = 0; k < NB; k++) send_beat(beats_a[k]);
        send_beat(beats_b[0]);
        in_valid = 1'b1;
        in_data  = beats_b[1];
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_A", A, '0);
        chk("midrst_B", B, '0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_data_mode", data_mode, 3'd0);
        chk("midrst_hi_flag", hi_flag, 1'b0);
        mdl_a = '0; mdl_b = '0; mdl_mode = 3'd0; mdl_hi = 1'b0;

`ifdef SIMD_LOADER_MODE_CHECK_EN
        // Reserved mode: accepted, err pulse, stays idle, fields unchanged.
        cmd_mode  = 3'd7;
        cmd_hi    = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("illegal_err_pulse", err, 1'b1);
        chk("illegal_stays_idle", cmd_ready, 1'b1);
        chk("illegal_in_ready", in_ready, 1'b0);
        chk("illegal_mode_kept", data_mode, mdl_mode);
        chk("illegal_hi_kept", hi_flag, mdl_hi);
        tick();
        chk("illegal_err_cleared", err, 1'b0);
        randomize_beats();
        run_txn(3'd5, 1'b1, 0, 0, lat);
`else
        randomize_beats();
        run_txn(3'd7, 1'b1, 0, 0, lat);
`endif

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            randomize_beats();
`ifdef SIMD_LOADER_MODE_CHECK_EN
            m = 3'($urandom_range(0, 5));
`else
            m = 3'($urandom_range(0, 7));
`endif
            run_txn(m, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), lat);
        end

        repeat (3) tick();
        chk("scoreboard_drained", SW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
